// File: rtl/bank_cmd_gen.sv
// Request FIFO plus open-page DRAM command sequencer: turns arbiter grants into
// PRE/ACT/RD/WR commands while tracking open rows and tRP/tRCD/tCCD timing.
module bank_cmd_gen #(
  parameter int INDEX_BITS = 7,
  parameter int RA_BITS    = 16,
  parameter int CA_BITS    = 10,
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int T_RP       = 3,
  parameter int T_RCD      = 3,
  parameter int T_CCD      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_BITS-1:0]  data_i,
  input  logic [INDEX_BITS-1:0] idx_i,
  input  logic [RA_BITS-1:0]    row_i,
  input  logic [CA_BITS-1:0]    col_i,
  input  logic                  t_i,
  input  logic [1:0]            ba_i,
  input  logic [1:0]            bg_i,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  ovf_err,
  output logic                  cmd_valid,
  output logic [2:0]            cmd,
  output logic [1:0]            cmd_ba,
  output logic [1:0]            cmd_bg,
  output logic [RA_BITS-1:0]    cmd_row,
  output logic [CA_BITS-1:0]    cmd_col,
  output logic [DATA_BITS-1:0]  cmd_data,
  output logic [INDEX_BITS-1:0] cmd_idx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  typedef struct packed {
    logic [DATA_BITS-1:0]  data;
    logic [INDEX_BITS-1:0] idx;
    logic [RA_BITS-1:0]    row;
    logic [CA_BITS-1:0]    col;
    logic                  t;
    logic [1:0]            ba;
    logic [1:0]            bg;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT_RP, WAIT_RCD} state_t;

  req_t                  fifo_mem [FIFO_DEPTH];
  req_t                  req_in;
  req_t                  head;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  state_t                state_q, state_d;
  logic [3:0]            tmr_q, tmr_d, ccd_q, ccd_d;
  logic [15:0]           bank_open_q, bank_open_d;
  logic [RA_BITS-1:0]    bank_row_q [16];

  logic                  cmd_valid_q, cmd_valid_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [1:0]            cmd_ba_q, cmd_ba_d, cmd_bg_q, cmd_bg_d;
  logic [RA_BITS-1:0]    cmd_row_q, cmd_row_d;
  logic [CA_BITS-1:0]    cmd_col_q, cmd_col_d;
  logic [DATA_BITS-1:0]  cmd_data_q, cmd_data_d;
  logic [INDEX_BITS-1:0] cmd_idx_q, cmd_idx_d;

  logic                  push, pop, at_depth;
  logic [3:0]            head_key;
  logic                  head_open, head_hit;
  logic                  do_act, do_pre, do_cas;

  assign req_in    = '{data: data_i, idx: idx_i, row: row_i, col: col_i,
                       t: t_i, ba: ba_i, bg: bg_i};
  assign head      = fifo_mem[rd_ptr_q];
  assign head_key  = {head.bg, head.ba};
  assign head_open = bank_open_q[head_key];
  assign head_hit  = (bank_row_q[head_key] == head.row);

  // Acceptance uses the live count, not the registered fifo_full view.
  assign at_depth  = (count_q == CW'(FIFO_DEPTH));
  assign push      = wr_en && !at_depth;
  assign pop       = do_cas;

  always_comb begin
    state_d     = state_q;
    tmr_d       = (tmr_q != 4'd0) ? tmr_q - 4'd1 : 4'd0;
    ccd_d       = (ccd_q != 4'd0) ? ccd_q - 4'd1 : 4'd0;
    bank_open_d = bank_open_q;
    do_act      = 1'b0;
    do_pre      = 1'b0;
    do_cas      = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          if (!head_open)          do_act = 1'b1;
          else if (!head_hit)      do_pre = 1'b1;
          else if (ccd_q == 4'd0)  do_cas = 1'b1;
        end
      end
      WAIT_RP: begin
        if (tmr_q == 4'd0) do_act = 1'b1;
      end
      WAIT_RCD: begin
        // The CAS may go out on the very edge tRCD elapses to keep spacing exact.
        if (tmr_q == 4'd0) begin
          state_d = IDLE;
          if (ccd_q == 4'd0) do_cas = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_valid_d = 1'b0;
    cmd_d       = CMD_NOP;
    cmd_ba_d    = '0;
    cmd_bg_d    = '0;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    cmd_data_d  = '0;
    cmd_idx_d   = '0;

    if (do_act) begin
      state_d               = WAIT_RCD;
      tmr_d                 = 4'(T_RCD - 1);
      bank_open_d[head_key] = 1'b1;
      cmd_valid_d           = 1'b1;
      cmd_d                 = CMD_ACT;
      cmd_ba_d              = head.ba;
      cmd_bg_d              = head.bg;
      cmd_row_d             = head.row;
    end
    if (do_pre) begin
      state_d               = WAIT_RP;
      tmr_d                 = 4'(T_RP - 1);
      bank_open_d[head_key] = 1'b0;
      cmd_valid_d           = 1'b1;
      cmd_d                 = CMD_PRE;
      cmd_ba_d              = head.ba;
      cmd_bg_d              = head.bg;
    end
    if (do_cas) begin
      ccd_d       = 4'(T_CCD - 1);
      cmd_valid_d = 1'b1;
      cmd_d       = head.t ? CMD_WR : CMD_RD;
      cmd_ba_d    = head.ba;
      cmd_bg_d    = head.bg;
      cmd_col_d   = head.col;
      cmd_idx_d   = head.idx;
      cmd_data_d  = head.t ? head.data : '0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    full_d   = (count_d == CW'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
    ovf_d    = ovf_q | (wr_en && at_depth);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= req_in;
  end

  // Row values are only meaningful while the matching open bit is set.
  for (genvar gi = 0; gi < 16; gi++) begin : g_row_tbl
    always_ff @(posedge clk) begin
      if (do_act && head_key == 4'(gi)) bank_row_q[gi] <= head.row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      ovf_q       <= 1'b0;
      state_q     <= IDLE;
      tmr_q       <= '0;
      ccd_q       <= '0;
      bank_open_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      cmd_ba_q    <= '0;
      cmd_bg_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      cmd_data_q  <= '0;
      cmd_idx_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      ccd_q       <= ccd_d;
      bank_open_q <= bank_open_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      cmd_data_q  <= cmd_data_d;
      cmd_idx_q   <= cmd_idx_d;
    end
  end

  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign ovf_err    = ovf_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd        = cmd_q;
  assign cmd_ba     = cmd_ba_q;
  assign cmd_bg     = cmd_bg_q;
  assign cmd_row    = cmd_row_q;
  assign cmd_col    = cmd_col_q;
  assign cmd_data   = cmd_data_q;
  assign cmd_idx    = cmd_idx_q;

endmodule

// File: tb/tb_bank_cmd_gen.sv
// Directed bench for bank_cmd_gen: logs every issued command with its cycle
// number and checks command order, fields and spacing against hand-derived values.
module tb_bank_cmd_gen;

  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] data_i;
  logic [6:0]  idx_i;
  logic [15:0] row_i;
  logic [9:0]  col_i;
  logic        t_i;
  logic [1:0]  ba_i, bg_i;
  logic        fifo_full, fifo_empty, ovf_err, cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  cmd_ba, cmd_bg;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [15:0] cmd_data;
  logic [6:0]  cmd_idx;

  bank_cmd_gen dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_i(data_i), .idx_i(idx_i),
    .row_i(row_i), .col_i(col_i), .t_i(t_i), .ba_i(ba_i), .bg_i(bg_i),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .ovf_err(ovf_err),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ba(cmd_ba), .cmd_bg(cmd_bg),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data), .cmd_idx(cmd_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  cmd;
    logic [1:0]  bg, ba;
    logic [15:0] row;
    logic [9:0]  col;
    logic [15:0] data;
    logic [6:0]  idx;
  } cmd_rec_t;

  cmd_rec_t mq[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_valid) begin
      mq.push_back('{cyc, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_data, cmd_idx});
      $display("[TB] cyc %0d cmd %0d bg %0d ba %0d row %0h col %0h data %0h idx %0d",
               cyc, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_data, cmd_idx);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] bg, input logic [1:0] ba, input logic [15:0] row,
                      input logic [9:0] col, input logic t, input logic [15:0] data,
                      input logic [6:0] idx);
    wr_en = 1'b1; bg_i = bg; ba_i = ba; row_i = row; col_i = col;
    t_i = t; data_i = data; idx_i = idx;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_n(input int n, input int budget, input string tag);
    int i = 0;
    while (mq.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 64'(mq.size() >= n), 64'd1);
  endtask

  int c0;
  int n_wr;

  initial begin
    rst = 1'b1; wr_en = 1'b0; data_i = '0; idx_i = '0; row_i = '0; col_i = '0;
    t_i = 1'b0; ba_i = '0; bg_i = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd", 64'(cmd), 64'd0);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_empty", 64'(fifo_empty), 64'd1);
    check("rst_ovf", 64'(ovf_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    mq.delete();

    // Closed bank read: ACT at C, RD at C+3
    c0 = cyc;
    push(2'd0, 2'd0, 16'd5, 10'd3, 1'b0, 16'h1234, 7'd1);
    wait_n(2, 20, "t1_wait");
    check("t1_act_cmd", 64'(mq[0].cmd), 64'(ACT));
    check("t1_act_lat", 64'(mq[0].cyc), 64'(c0 + 2));
    check("t1_act_row", 64'(mq[0].row), 64'd5);
    check("t1_act_col", 64'(mq[0].col), 64'd0);
    check("t1_rd_cmd", 64'(mq[1].cmd), 64'(RD));
    check("t1_rd_gap", 64'(mq[1].cyc - mq[0].cyc), 64'd3);
    check("t1_rd_col", 64'(mq[1].col), 64'd3);
    check("t1_rd_idx", 64'(mq[1].idx), 64'd1);
    check("t1_rd_data", 64'(mq[1].data), 64'd0);
    check("t1_rd_row", 64'(mq[1].row), 64'd0);
    repeat (2) @(negedge clk);
    check("t1_empty", 64'(fifo_empty), 64'd1);
    mq.delete();

    // Hit stream: three RDs exactly 2 cycles apart
    c0 = cyc;
    push(2'd0, 2'd0, 16'd5, 10'd4, 1'b0, 16'd0, 7'd2);
    push(2'd0, 2'd0, 16'd5, 10'd5, 1'b0, 16'd0, 7'd3);
    push(2'd0, 2'd0, 16'd5, 10'd6, 1'b0, 16'd0, 7'd4);
    wait_n(3, 30, "t2_wait");
    check("t2_first_lat", 64'(mq[0].cyc), 64'(c0 + 2));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_cmd%0d", i), 64'(mq[i].cmd), 64'(RD));
      check($sformatf("t2_col%0d", i), 64'(mq[i].col), 64'(4 + i));
      check($sformatf("t2_idx%0d", i), 64'(mq[i].idx), 64'(2 + i));
    end
    check("t2_gap01", 64'(mq[1].cyc - mq[0].cyc), 64'd2);
    check("t2_gap12", 64'(mq[2].cyc - mq[1].cyc), 64'd2);
    repeat (5) @(negedge clk);
    check("t2_no_extra", 64'(mq.size()), 64'd3);
    mq.delete();

    // Conflict write: PRE, ACT +3, WR +6
    c0 = cyc;
    push(2'd0, 2'd0, 16'd9, 10'd7, 1'b1, 16'hBEEF, 7'd5);
    wait_n(3, 30, "t3_wait");
    check("t3_pre_cmd", 64'(mq[0].cmd), 64'(PRE));
    check("t3_pre_lat", 64'(mq[0].cyc), 64'(c0 + 2));
    check("t3_pre_row", 64'(mq[0].row), 64'd0);
    check("t3_act_cmd", 64'(mq[1].cmd), 64'(ACT));
    check("t3_act_gap", 64'(mq[1].cyc - mq[0].cyc), 64'd3);
    check("t3_act_row", 64'(mq[1].row), 64'd9);
    check("t3_wr_cmd", 64'(mq[2].cmd), 64'(WR));
    check("t3_wr_gap", 64'(mq[2].cyc - mq[0].cyc), 64'd6);
    check("t3_wr_col", 64'(mq[2].col), 64'd7);
    check("t3_wr_data", 64'(mq[2].data), 64'hBEEF);
    check("t3_wr_idx", 64'(mq[2].idx), 64'd5);
    repeat (3) @(negedge clk);
    mq.delete();

    // Bank isolation: same row in another bank must not alias as a hit
    push(2'd1, 2'd2, 16'd4, 10'd0, 1'b0, 16'd0, 7'd6);
    wait_n(2, 20, "t4a_wait");
    check("t4a_act", 64'(mq[0].cmd), 64'(ACT));
    check("t4a_bank", 64'({mq[0].bg, mq[0].ba}), 64'h6);
    repeat (3) @(negedge clk);
    mq.delete();
    push(2'd2, 2'd1, 16'd4, 10'd0, 1'b0, 16'd0, 7'd7);
    wait_n(2, 20, "t4b_wait");
    check("t4b_act", 64'(mq[0].cmd), 64'(ACT));
    check("t4b_bank", 64'({mq[0].bg, mq[0].ba}), 64'h9);
    check("t4b_rd", 64'(mq[1].cmd), 64'(RD));
    repeat (3) @(negedge clk);
    mq.delete();
    push(2'd1, 2'd2, 16'd4, 10'd8, 1'b0, 16'd0, 7'd8);
    wait_n(1, 20, "t4c_wait");
    check("t4c_rd", 64'(mq[0].cmd), 64'(RD));
    check("t4c_bank", 64'({mq[0].bg, mq[0].ba}), 64'h6);
    check("t4c_col", 64'(mq[0].col), 64'd8);
    repeat (6) @(negedge clk);
    check("t4c_no_extra", 64'(mq.size()), 64'd1);
    mq.delete();

    // Overflow: 10 back-to-back conflicting writes, 10th dropped
    for (int i = 0; i < 10; i++)
      push(2'd0, 2'd0, 16'(100 + i), 10'(i), 1'b1, 16'(i), 7'(i));
    check("t5_full", 64'(fifo_full), 64'd1);
    check("t5_ovf", 64'(ovf_err), 64'd1);
    wait_n(27, 300, "t5_wait");
    repeat (12) @(negedge clk);
    check("t5_cmd_total", 64'(mq.size()), 64'd27);
    n_wr = 0;
    foreach (mq[i]) if (mq[i].cmd == WR) n_wr++;
    check("t5_wr_count", 64'(n_wr), 64'd9);
    check("t5_last_data", 64'(mq[mq.size() - 1].data), 64'd8);
    check("t5_empty", 64'(fifo_empty), 64'd1);
    check("t5_ovf_sticky", 64'(ovf_err), 64'd1);
    mq.delete();

    // Reset during WAIT_RCD abandons the pending RD and clears the table
    push(2'd3, 2'd3, 16'd7, 10'd2, 1'b0, 16'd0, 7'd9);
    wait_n(1, 20, "t6_act_wait");
    check("t6_act", 64'(mq[0].cmd), 64'(ACT));
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", 64'(cmd_valid), 64'd0);
    check("t6_rst_cmd", 64'(cmd), 64'd0);
    check("t6_rst_row", 64'(cmd_row), 64'd0);
    check("t6_rst_empty", 64'(fifo_empty), 64'd1);
    check("t6_rst_full", 64'(fifo_full), 64'd0);
    check("t6_rst_ovf", 64'(ovf_err), 64'd0);
    rst = 1'b0;
    mq.delete();
    repeat (5) @(negedge clk);
    check("t6_no_cmd", 64'(mq.size()), 64'd0);
    c0 = cyc;
    push(2'd3, 2'd3, 16'd7, 10'd2, 1'b0, 16'd0, 7'd9);
    wait_n(2, 20, "t6_re_wait");
    check("t6_re_act", 64'(mq[0].cmd), 64'(ACT));
    check("t6_re_lat", 64'(mq[0].cyc), 64'(c0 + 2));
    check("t6_re_rd", 64'(mq[1].cmd), 64'(RD));
    check("t6_re_gap", 64'(mq[1].cyc - mq[0].cyc), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bank_cmd_gen.md
# bank_cmd_gen

Back-end stage directly downstream of the 16-bank arbiter: captures each granted request (arbiter `wr_en` plus data/idx/row/col/type/ba/bg) into a small FIFO and converts it into a legal DRAM command sequence (PRE/ACT/RD/WR) toward the PHY. It keeps a 16-entry open-row table, one entry per {bg,ba}, and enforces tRP, tRCD and tCCD with down-counters. It issues at most one command per cycle and exposes `fifo_full` as back-pressure to the arbiter.

## Interface
- INDEX_BITS, 7, request index width
- RA_BITS, 16, row address width
- CA_BITS, 10, column address width
- DATA_BITS, 16, write data width
- FIFO_DEPTH, 8, request FIFO entries (power of 2, ≥2)
- T_RP, 3, min cycles PRE→ACT same bank (1..15)
- T_RCD, 3, min cycles ACT→RD/WR same bank (1..15)
- T_CCD, 2, min cycles between any two RD/WR (1..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  arbiter output valid; push request
- data_i  in  DATA_BITS  write data
- idx_i  in  INDEX_BITS  request index
- row_i  in  RA_BITS  row
- col_i  in  CA_BITS  column
- t_i  in  1  type: 1 = write, 0 = read
- ba_i  in  2  bank address
- bg_i  in  2  bank group
- fifo_full  out  1  FIFO full; arbiter must hold off
- fifo_empty  out  1  FIFO empty
- ovf_err  out  1  sticky: push attempted while full
- cmd_valid  out  1  command on cmd_* this cycle
- cmd  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
- cmd_ba, cmd_bg  out  2 each  target bank
- cmd_row  out  RA_BITS  row (ACT only, else 0)
- cmd_col  out  CA_BITS  column (RD/WR only, else 0)
- cmd_data  out  DATA_BITS  data (WR only, else 0)
- cmd_idx  out  INDEX_BITS  request index (RD/WR only, else 0)

## Operation
- FIFO: push when wr_en && !fifo_full; when wr_en && fifo_full, request dropped, ovf_err set until rst. Pop only when head's RD/WR issues. Simultaneous push/pop when not full: both occur, count unchanged.
- Bank key = {bg,ba} (0..15). Table entry: open bit + row.
- FSM states: IDLE, WAIT_RP, WAIT_RCD.
  - IDLE, FIFO non-empty, head bank:
    - open, row match (hit) → RD/WR when tCCD counter = 0, else wait in IDLE.
    - closed → ACT, mark open with head row, go WAIT_RCD.
    - open, row mismatch (conflict) → PRE, mark closed, go WAIT_RP.
  - WAIT_RP: when elapsed → ACT, go WAIT_RCD.
  - WAIT_RCD: when elapsed → IDLE; head is now a hit.
- Strictly in-order; no reordering, no speculative ACT to other banks.
- Rows stay open after CAS (open-page); no auto-precharge, no refresh.
- All cmd_* outputs registered; cmd_valid pulses one cycle per command; otherwise cmd = NOP and fields 0.

## Timing
- Reset: cmd_valid 0, cmd 0, all cmd_* fields 0, fifo_full 0, fifo_empty 1, ovf_err 0; FIFO emptied, all banks closed, counters 0, FSM IDLE. Reset mid-sequence abandons everything, including a pending ACT or CAS; no command emitted in the cycle after rst deasserts.
- Latency: request sampled at edge E0 → first command visible after E1 (2 edges), if the bank is idle and no timer is active.
- Spacing is measured between cmd_valid cycles and is exact when no other constraint intervenes. PRE→ACT = T_RP, ACT→RD/WR = T_RCD, RD/WR→RD/WR ≥ T_CCD; back-to-back hits = exactly T_CCD.
- fifo_full asserts the cycle after the count reaches FIFO_DEPTH. It is a registered view; a push in that same edge is still checked against the internal count.
- Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

## Test plan
- Closed bank read: push bg0 ba0 row 5 col 3 t0 idx 1 → ACT row 5 at cycle C, RD col 3 idx 1 at C+3; fifo_empty returns to 1.
- Hit stream: after above, push 3 reads row 5 cols 4,5,6 → three RDs spaced exactly 2 cycles, no ACT/PRE.
- Conflict write: bank 0 open row 5, push row 9 col 7 t1 data 0xBEEF → PRE at C, ACT row 9 at C+3, WR col 7 data 0xBEEF at C+6.
- Bank isolation: open bg1 ba2 row 4, then request bg2 ba1 row 4 → ACT issued (no hit aliasing); later bg1 ba2 row 4 → RD with no ACT.
- Overflow: 10 back-to-back conflicting pushes → fifo_full asserts, 10th push dropped, ovf_err stays 1; exactly 9 or fewer RD/WR per accounting of accepted pushes.
- Reset mid-op: assert rst during WAIT_RCD → next cycle all outputs at reset values, fifo_empty 1; the same request re-pushed → ACT again (table cleared).
